// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;
   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;
   localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

   typedef enum logic {
      FETCH = 1'b0,
      DRAIN = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fifo_entry_t;
endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO of {instr, pc} entries with push/pop/flush and registered head storage.
module if_prefetch_fifo
   import if_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  fifo_entry_t      push_data,
   input  logic             pop,
   input  logic             flush,
   output fifo_entry_t      head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);
   fifo_entry_t      mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [CNT_W-1:0] count_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CNT_W'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
            wr_ptr_reg      <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

   assign head  = mem[rd_ptr_reg];
   assign count = count_reg;
endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: fetch PC, in-order imem requests, prefetch FIFO, redirect draining.
// Optional macro IF_PERF_CNT_EN adds the perf_fetched / perf_dropped event counters.
module if_fetch_stage
   import if_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC        = 32'h0000_0000,
   parameter int                FIFO_DEPTH      = 4,
   parameter int                MAX_OUTSTANDING = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc4
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_dropped
`endif
);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [CNT_W:0] MAX_C   = (CNT_W+1)'(MAX_OUTSTANDING);

   fetch_state_t      state_reg;
   logic [ADDR_W-1:0] fetch_pc_reg;
   logic [CNT_W-1:0]  outstanding_reg;
   logic [CNT_W-1:0]  outstanding_next;
   logic [CNT_W-1:0]  drop_cnt_reg;
   logic [CNT_W-1:0]  drop_cnt_next;
   logic              active_reg;
   logic [ADDR_W-1:0] tag_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  tag_wr_ptr_reg;
   logic [PTR_W-1:0]  tag_rd_ptr_reg;
   logic              handshake;
   logic              pop;
   logic              rsp_keep;
   logic              rsp_drop;
   logic [ADDR_W-1:0] redirect_target;
   logic [CNT_W:0]    credit_used;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   fifo_entry_t       fifo_push_data;
   fifo_entry_t       fifo_head;

   assign redirect_target = redirect_pc & {{(ADDR_W-2){1'b1}}, 2'b00};
   assign credit_used     = {1'b0, outstanding_reg} + {1'b0, fifo_count};

   // Every granted request owns a FIFO slot, so responses can never overflow it.
   assign imem_req  = active_reg & ~redirect_valid & ~fifo_full &
                      ({1'b0, outstanding_reg} < MAX_C) & (credit_used < DEPTH_C);
   assign imem_addr = fetch_pc_reg;
   assign handshake = imem_req & imem_gnt;
   assign pop       = id_valid & id_ready;
   assign rsp_keep  = imem_rvalid & (state_reg == FETCH) & ~redirect_valid;
   assign rsp_drop  = imem_rvalid & ~rsp_keep;

   always_comb begin
      outstanding_next = outstanding_reg;
      if (handshake & ~imem_rvalid) begin
         outstanding_next = outstanding_reg + 1'b1;
      end else if (~handshake & imem_rvalid) begin
         outstanding_next = outstanding_reg - 1'b1;
      end
   end

   // Outstanding already counts responses still pending a drop, so a redirect makes
   // every in-flight word stale: repeated redirects accumulate without double counting.
   always_comb begin
      drop_cnt_next = drop_cnt_reg;
      if (redirect_valid) begin
         drop_cnt_next = outstanding_reg - CNT_W'(imem_rvalid);
      end else if (rsp_drop) begin
         drop_cnt_next = drop_cnt_reg - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= FETCH;
         fetch_pc_reg    <= RESET_PC;
         outstanding_reg <= '0;
         drop_cnt_reg    <= '0;
         active_reg      <= 1'b0;
         tag_wr_ptr_reg  <= '0;
         tag_rd_ptr_reg  <= '0;
      end else begin
         active_reg      <= 1'b1;
         outstanding_reg <= outstanding_next;
         drop_cnt_reg    <= drop_cnt_next;
         if (redirect_valid) begin
            fetch_pc_reg <= redirect_target;
         end else if (handshake) begin
            fetch_pc_reg <= fetch_pc_reg + PC_STEP;
         end
         if (handshake) begin
            tag_wr_ptr_reg <= tag_wr_ptr_reg + 1'b1;
         end
         if (imem_rvalid) begin
            tag_rd_ptr_reg <= tag_rd_ptr_reg + 1'b1;
         end
         case (state_reg)
            FETCH:   if (redirect_valid && drop_cnt_next != '0) state_reg <= DRAIN;
            DRAIN:   if (drop_cnt_next == '0) state_reg <= FETCH;
            default: state_reg <= FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (handshake) begin
         tag_mem[tag_wr_ptr_reg] <= fetch_pc_reg;
      end
   end

   assign fifo_push_data.instr = imem_rdata;
   assign fifo_push_data.pc    = tag_mem[tag_rd_ptr_reg];

   if_prefetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_prefetch_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (rsp_keep),
      .push_data (fifo_push_data),
      .pop       (pop),
      .flush     (redirect_valid),
      .head      (fifo_head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign id_valid = ~fifo_empty;
   assign id_instr = fifo_head.instr;
   assign id_pc    = fifo_head.pc;
   assign id_pc4   = fifo_head.pc + PC_STEP;

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched_reg;
   logic [31:0] perf_dropped_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched_reg <= '0;
         perf_dropped_reg <= '0;
      end else begin
         if (rsp_keep) perf_fetched_reg <= perf_fetched_reg + 1'b1;
         if (rsp_drop) perf_dropped_reg <= perf_dropped_reg + 1'b1;
      end
   end

   assign perf_fetched = perf_fetched_reg;
   assign perf_dropped = perf_dropped_reg;
`endif
endmodule
